mem_wb_stage: RTL
=================

# mem_wb_stage

MEM/WB pipeline stage sitting directly downstream of the data memory. Captures each retiring instruction's opcode, destination register, ALU result and the data memory's `read_data` into a 2-entry skid buffer. Drives the register-file write port, selecting zero-extended load data for loads and the ALU result for everything else. Also provides a forwarding tap and a retired-instruction counter.

## Interface
- `REG_ADDR_W`, 2: destination register index width.
- `CNT_W`, 16: retired-instruction counter width.
- `clk` input 1: sole clock; all state updates on posedge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: upstream presents an instruction this cycle.
- `in_ready` output 1: stage can accept; transfer occurs on a posedge with `in_valid && in_ready`.
- `in_op` input 4: opcode (byte-1 encoding; 4'b1101 load, 4'b1110 store).
- `in_rd` input REG_ADDR_W: destination register index.
- `in_alu` input 10: ALU result.
- `in_mem` input 8: data memory `read_data`.
- `wb_stall` input 1: register file cannot take a write this cycle.
- `wb_en` output 1: register-file write enable.
- `wb_addr` output REG_ADDR_W: write index.
- `wb_data` output 10: write data.
- `fwd_valid` output 1: youngest buffered entry writes a register.
- `fwd_addr` output REG_ADDR_W: that entry's destination.
- `fwd_data` output 10: that entry's write data.
- `retired` output CNT_W: count of retired instructions.

## Operation
- **Buffer.** 2-entry FIFO: head and tail registers plus a 2-bit `count` (0..2).
- **Stored fields.** Each entry holds a `writes` flag and a 10-bit data value, plus `in_rd`.
  - Load (4'b1101): data = {2'b00, in_mem}; `writes` = 1.
  - Store (4'b1110): `writes` = 0; data don't-care.
  - Any other op: data = `in_alu`; `writes` = 1.
  - Result selection happens at capture time, so `in_mem` only needs to be valid in the accept cycle.
- **`in_ready`.** Equals `(count != 2) && !reset`. It is derived from registered state only, with no combinational path from `in_valid` or `wb_stall`.
- **Retire.** A retire occurs on a posedge where `count != 0 && !wb_stall`. The head is popped whether or not it writes, and `retired` increments by 1.
- **Writeback outputs.**
  - `wb_en` = `count != 0 && head.writes && !wb_stall`.
  - `wb_addr`/`wb_data` reflect the head entry whenever `count != 0`, and are 0 when empty.
- **Forwarding.**
  - `fwd_*` reflect the youngest entry: tail if `count == 2`, head if `count == 1`.
  - `fwd_valid` = `count != 0 && youngest.writes`.
  - `fwd_addr`/`fwd_data` are 0 when `fwd_valid` is low.
- **Count transitions per edge.**
  - Accept only: +1.
  - Retire only: −1.
  - Both: unchanged. The head is replaced by the old tail, or by the new entry when `count` was 1.
  - Neither: unchanged.
- **`count == 2`.** No accept is possible. A retire moves the tail to the head.
- **`count == 0`.** No retire is possible; `wb_stall` is ignored.
- **Counter.** `retired` wraps from 2^CNT_W−1 to 0 without a flag.
- **Reset.**
  - Clears `count` and `retired`.
  - Entry contents are cleared to 0.
  - Any in-flight entries are discarded without writeback.
  - An `in_valid` asserted during reset is not accepted.

## Timing
- **Reset values:** `in_ready` 0 while `reset` is high and 1 on the first cycle after. `wb_en`, `wb_addr`, `wb_data`, `fwd_valid`, `fwd_addr`, `fwd_data` and `retired` are all 0.
- **Latency.** An instruction accepted at edge N into an empty buffer appears on `wb_*` during cycle N..N+1. With `wb_stall` low it is written and retired at edge N+1 (1-cycle latency).
- **Throughput.** One instruction per cycle sustained with `wb_stall` low; `count` stays ≤1.
- **Stall behaviour.** Two accepts without a retire fill the buffer, and `in_ready` drops the cycle after the second accept. When `wb_stall` falls, `in_ready` rises one cycle after the first retire.
- **Write timing.** The register file samples `wb_en`/`wb_addr`/`wb_data` on the same posedge that retires the entry. The data memory's negedge store therefore completes before the stage observes the next load in the same pipeline.

## Test plan
- **Reset then load.** Assert reset 2 cycles, then accept op=4'b1101, rd=2, in_mem=8'hA5 → next cycle `wb_en`=1, `wb_addr`=2, `wb_data`=10'h0A5; `retired`=1 after that edge.
- **Store then ALU.** Accept a store, then op=4'b0001 rd=1 alu=10'h3FF back-to-back with `wb_stall`=0 → `wb_en` low in the store's cycle and high in the next with data 10'h3FF; `retired`=2.
- **Full-buffer stall.** Hold `wb_stall`=1 and offer 3 instructions:
  - The first two are accepted and `in_ready`=0 thereafter.
  - `fwd_*` shows the second entry.
  - Release the stall → writes occur in order on consecutive cycles and the third is accepted the cycle after the first retire.
- **Simultaneous accept and retire at `count`=1.** Steady streaming of 10 ALU ops → `count` stays 1, one `wb_en` per cycle, in order, with no bubbles.
- **Reset mid-operation.** Fill 2 entries under stall, then assert `reset` for 1 cycle → no `wb_en`, and `retired`=0, `fwd_valid`=0, `in_ready`=1 afterwards.
- **Counter wrap.** Run with CNT_W=4 and retire 17 instructions → `retired`=1.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: captures retiring instructions into a 2-entry skid buffer and drives
// the register-file write port, a forwarding tap and a retired-instruction counter.
module mem_wb_stage #(
  parameter int REG_ADDR_W = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [9:0]            in_alu,
  input  logic [7:0]            in_mem,
  input  logic                  wb_stall,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [9:0]            wb_data,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_addr,
  output logic [9:0]            fwd_data,
  output logic [CNT_W-1:0]      retired
);

  localparam logic [3:0] OP_LOAD  = 4'b1101;
  localparam logic [3:0] OP_STORE = 4'b1110;

  logic [1:0]            count_q, count_d;
  logic                  head_writes_q, head_writes_d;
  logic [REG_ADDR_W-1:0] head_rd_q, head_rd_d;
  logic [9:0]            head_data_q, head_data_d;
  logic                  tail_writes_q, tail_writes_d;
  logic [REG_ADDR_W-1:0] tail_rd_q, tail_rd_d;
  logic [9:0]            tail_data_q, tail_data_d;
  logic [CNT_W-1:0]      retired_q, retired_d;

  logic                  accept_s;
  logic                  retire_s;
  logic                  new_writes_s;
  logic [9:0]            new_data_s;
  logic                  young_writes_s;
  logic [REG_ADDR_W-1:0] young_rd_s;
  logic [9:0]            young_data_s;

  // Result selection is done here so in_mem only matters in the accept cycle.
  always_comb begin
    new_writes_s = 1'b1;
    new_data_s   = in_alu;
    case (in_op)
      OP_LOAD: begin
        new_writes_s = 1'b1;
        new_data_s   = {2'b00, in_mem};
      end
      OP_STORE: begin
        new_writes_s = 1'b0;
        new_data_s   = 10'd0;
      end
      default: begin
        new_writes_s = 1'b1;
        new_data_s   = in_alu;
      end
    endcase
  end

  assign in_ready = (count_q != 2'd2) && !reset;
  assign accept_s = in_valid && in_ready;
  assign retire_s = (count_q != 2'd0) && !wb_stall;

  // Buffer occupancy and entry movement for accept/retire combinations.
  always_comb begin
    count_d       = count_q;
    head_writes_d = head_writes_q;
    head_rd_d     = head_rd_q;
    head_data_d   = head_data_q;
    tail_writes_d = tail_writes_q;
    tail_rd_d     = tail_rd_q;
    tail_data_d   = tail_data_q;
    case (count_q)
      2'd0: begin
        if (accept_s) begin
          head_writes_d = new_writes_s;
          head_rd_d     = in_rd;
          head_data_d   = new_data_s;
          count_d       = 2'd1;
        end else begin
          count_d = 2'd0;
        end
      end
      2'd1: begin
        if (accept_s && retire_s) begin
          head_writes_d = new_writes_s;
          head_rd_d     = in_rd;
          head_data_d   = new_data_s;
        end else if (accept_s) begin
          tail_writes_d = new_writes_s;
          tail_rd_d     = in_rd;
          tail_data_d   = new_data_s;
          count_d       = 2'd2;
        end else if (retire_s) begin
          count_d = 2'd0;
        end else begin
          count_d = 2'd1;
        end
      end
      2'd2: begin
        if (retire_s) begin
          head_writes_d = tail_writes_q;
          head_rd_d     = tail_rd_q;
          head_data_d   = tail_data_q;
          count_d       = 2'd1;
        end else begin
          count_d = 2'd2;
        end
      end
      default: begin
        count_d = 2'd0;
      end
    endcase
  end

  // Retired counter wraps silently.
  always_comb begin
    if (retire_s) begin
      retired_d = retired_q + CNT_W'(1);
    end else begin
      retired_d = retired_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q       <= 2'd0;
      head_writes_q <= 1'b0;
      head_rd_q     <= '0;
      head_data_q   <= 10'd0;
      tail_writes_q <= 1'b0;
      tail_rd_q     <= '0;
      tail_data_q   <= 10'd0;
      retired_q     <= '0;
    end else begin
      count_q       <= count_d;
      head_writes_q <= head_writes_d;
      head_rd_q     <= head_rd_d;
      head_data_q   <= head_data_d;
      tail_writes_q <= tail_writes_d;
      tail_rd_q     <= tail_rd_d;
      tail_data_q   <= tail_data_d;
      retired_q     <= retired_d;
    end
  end

  // Writeback port presents the head entry; zero when empty.
  always_comb begin
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_data = 10'd0;
    if (count_q != 2'd0) begin
      wb_en   = head_writes_q && !wb_stall;
      wb_addr = head_rd_q;
      wb_data = head_data_q;
    end else begin
      wb_en   = 1'b0;
      wb_addr = '0;
      wb_data = 10'd0;
    end
  end

  // Forwarding tap follows the youngest buffered entry.
  always_comb begin
    young_writes_s = head_writes_q;
    young_rd_s     = head_rd_q;
    young_data_s   = head_data_q;
    fwd_valid      = 1'b0;
    fwd_addr       = '0;
    fwd_data       = 10'd0;
    if (count_q == 2'd2) begin
      young_writes_s = tail_writes_q;
      young_rd_s     = tail_rd_q;
      young_data_s   = tail_data_q;
    end else begin
      young_writes_s = head_writes_q;
      young_rd_s     = head_rd_q;
      young_data_s   = head_data_q;
    end
    if ((count_q != 2'd0) && young_writes_s) begin
      fwd_valid = 1'b1;
      fwd_addr  = young_rd_s;
      fwd_data  = young_data_s;
    end else begin
      fwd_valid = 1'b0;
      fwd_addr  = '0;
      fwd_data  = 10'd0;
    end
  end

  assign retired = retired_q;

endmodule
